// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//
// Purpose:
//   Groups the fetch-stage bus signals: the ROM address/data pair, the
//   instruction handshake toward decode, the redirect request and the stall
//   indication.
//
// Signals:
//   rom_addr    32  byte address to ROM (word aligned)
//   rom_data    32  ROM read data
//   instr       32  FIFO head instruction, 0 when empty
//   instr_pc    32  byte address of instr, 0 when empty
//   instr_valid  1  head available and no redirect this cycle
//   instr_ready  1  decode accepts the head this cycle
//   redirect     1  flush and restart fetch at redirect_pc
//   redirect_pc 32  new fetch PC (low two bits ignored)
//   stalled      1  fetch is holding because the FIFO is full
//
// Modports:
//   master  the fetch stage
//   slave   the surroundings (ROM, decode, branch unit)
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stalled;

  modport master (
    output rom_addr,
    output instr,
    output instr_pc,
    output instr_valid,
    output stalled,
    input  rom_data,
    input  instr_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  rom_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  stalled,
    output rom_data,
    output instr_ready,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage in front of a slow asynchronous word ROM. Owns the program
//   counter, holds the ROM address for WAIT_CYCLES edges before sampling the
//   data, and queues {instruction, pc} pairs in a small circular FIFO toward
//   decode. A redirect flushes the FIFO and restarts fetch at a new PC.
//
// Parameters:
//   RESET_PC     PC after reset (word aligned)
//   WAIT_CYCLES  edges the address is held before rom_data is sampled (>= 1)
//   DEPTH        instruction FIFO entries (>= 1)
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      instruction_fetch_if.master (ROM, decode handshake, redirect)
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instruction_fetch_if.master   bus
);

  localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DEPTH);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        instr_mem_d [DEPTH];
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        pc_mem_d    [DEPTH];

  logic has_data;
  logic full;
  logic do_push;
  logic do_pop;

  // The low address bits of a redirect target are discarded by design.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = bus.redirect_pc[1:0];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign has_data = (count_q != '0);
  assign full     = (count_q == COUNT_FULL);

  // The ROM address comes straight from the PC flop so it is glitch-free.
  // The head outputs read zero whenever the FIFO is empty, and a redirect
  // masks valid combinationally so decode never takes a stale word.
  assign bus.rom_addr    = pc_q;
  assign bus.instr_valid = has_data && !bus.redirect;
  assign bus.instr       = has_data ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = has_data ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.stalled     = (state_q == S_FULL);

  // Next-state logic. Fullness is judged on the registered count, so a pop
  // at full never makes room for a push on the same edge; FULL simply
  // retries on the following edge while the ROM data is still held valid.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;

    if (bus.redirect) begin
      state_d  = S_WAIT;
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      cnt_d    = '0;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      do_pop = has_data && bus.instr_ready;

      case (state_q)
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            if (!full) begin
              do_push = 1'b1;
            end else begin
              state_d = S_FULL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_FULL: begin
          if (!full) begin
            do_push = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_WAIT;
      endcase

      if (do_push) begin
        instr_mem_d[wr_ptr_q] = bus.rom_data;
        pc_mem_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = ptr_next(wr_ptr_q);
        pc_d                  = pc_q + 32'd4;
        cnt_d                 = '0;
      end

      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end

      case ({do_push, do_pop})
        2'b10:   count_d = count_q + COUNT_W'(1);
        2'b01:   count_d = count_q - COUNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous reset; reset clears every FIFO entry
  // so the outputs are defined immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_WAIT;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Purpose:
//   Directed bench for instruction_fetch with a behavioural 90-unit ROM.
//   Clock period 100, WAIT_CYCLES = 2, DEPTH = 2, RESET_PC = 0.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC    (32'h0000_0000),
    .WAIT_CYCLES (2),
    .DEPTH       (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock: rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ROM contents used by the directed vectors.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1111_1111;
      32'h0000_0004: return 32'h2222_2222;
      32'h0000_0008: return 32'h3333_3333;
      32'h0000_000C: return 32'h4444_4444;
      32'hFFFF_FFFC: return 32'hDEAD_BEEF;
      default:       return ~a;
    endcase
  endfunction

  // Asynchronous ROM: data follows the address after 90 time units.
  initial begin
    forever begin
      bus.rom_data <= #90 rom_word(bus.rom_addr);
      @(bus.rom_addr);
    end
  end

  // Overall time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir,
                               input logic [31:0] redir_pc);
    bus.instr_ready = ready;
    bus.redirect    = redir;
    bus.redirect_pc = redir_pc;
  endtask

  // Advance n rising edges and stop at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Synchronous-looking reset pulse driven from a falling edge.
  task automatic resetDut();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);

    // Reset values and the nominal stream.
    @(negedge clk);
    $display("[TB] reset and stream");
    checkOutput("rst_rom_addr", bus.rom_addr, 32'h0);
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
    checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rst_stalled", {31'b0, bus.stalled}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    checkOutput("s1_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("s1_rom_addr", bus.rom_addr, 32'h0);
    tick(1);
    checkOutput("s2_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("s2_instr", bus.instr, 32'h1111_1111);
    checkOutput("s2_pc", bus.instr_pc, 32'h0);
    checkOutput("s2_rom_addr", bus.rom_addr, 32'h4);
    tick(1);
    checkOutput("s3_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick(1);
    checkOutput("s4_instr", bus.instr, 32'h2222_2222);
    checkOutput("s4_pc", bus.instr_pc, 32'h4);
    checkOutput("s4_rom_addr", bus.rom_addr, 32'h8);
    tick(2);
    checkOutput("s6_instr", bus.instr, 32'h3333_3333);
    checkOutput("s6_pc", bus.instr_pc, 32'h8);
    checkOutput("s6_rom_addr", bus.rom_addr, 32'hC);

    // Backpressure into the FULL state and recovery.
    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 32'h0);
    resetDut();
    tick(2);
    checkOutput("bp2_instr", bus.instr, 32'h1111_1111);
    checkOutput("bp2_rom_addr", bus.rom_addr, 32'h4);
    tick(2);
    checkOutput("bp4_stalled", {31'b0, bus.stalled}, 32'h0);
    checkOutput("bp4_rom_addr", bus.rom_addr, 32'h8);
    tick(2);
    checkOutput("bp6_stalled", {31'b0, bus.stalled}, 32'h1);
    checkOutput("bp6_rom_addr", bus.rom_addr, 32'h8);
    checkOutput("bp6_pc", bus.instr_pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    checkOutput("bp7_pc", bus.instr_pc, 32'h4);
    checkOutput("bp7_stalled", {31'b0, bus.stalled}, 32'h1);
    checkOutput("bp7_rom_addr", bus.rom_addr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick(1);
    checkOutput("bp8_stalled", {31'b0, bus.stalled}, 32'h0);
    checkOutput("bp8_rom_addr", bus.rom_addr, 32'hC);
    checkOutput("bp8_pc", bus.instr_pc, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    checkOutput("bp9_instr", bus.instr, 32'h3333_3333);
    checkOutput("bp9_pc", bus.instr_pc, 32'h8);

    // Redirect mid-wait with one entry queued.
    $display("[TB] redirect");
    applyStimulus(1'b1, 1'b0, 32'h0);
    resetDut();
    tick(4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick(1);
    checkOutput("rd_pre_pc", bus.instr_pc, 32'h4);
    checkOutput("rd_pre_rom_addr", bus.rom_addr, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h0000_000E);
    #1;
    checkOutput("rd_valid_mask", {31'b0, bus.instr_valid}, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rd_flush_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rd_rom_addr", bus.rom_addr, 32'hC);
    tick(2);
    checkOutput("rd_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("rd_instr", bus.instr, 32'h4444_4444);
    checkOutput("rd_pc", bus.instr_pc, 32'hC);

    // PC wrap at the top of the address space.
    $display("[TB] wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wr_rom_addr", bus.rom_addr, 32'hFFFF_FFFC);
    tick(2);
    checkOutput("wr_instr", bus.instr, 32'hDEAD_BEEF);
    checkOutput("wr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    checkOutput("wr_rom_addr_next", bus.rom_addr, 32'h0);

    // Asynchronous reset between edges while FULL.
    $display("[TB] async reset");
    applyStimulus(1'b0, 1'b0, 32'h0);
    resetDut();
    tick(6);
    checkOutput("ar_stalled_pre", {31'b0, bus.stalled}, 32'h1);
    #10;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_rom_addr", bus.rom_addr, 32'h0);
    checkOutput("ar_instr", bus.instr, 32'h0);
    checkOutput("ar_pc", bus.instr_pc, 32'h0);
    checkOutput("ar_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("ar_stalled", {31'b0, bus.stalled}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    checkOutput("ar1_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick(1);
    checkOutput("ar2_instr", bus.instr, 32'h1111_1111);
    checkOutput("ar2_pc", bus.instr_pc, 32'h0);

    // Redirect together with ready while full: no pop, no push.
    $display("[TB] redirect at full");
    applyStimulus(1'b0, 1'b0, 32'h0);
    resetDut();
    tick(6);
    checkOutput("rf_stalled_pre", {31'b0, bus.stalled}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0004);
    #1;
    checkOutput("rf_valid_mask", {31'b0, bus.instr_valid}, 32'h0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rf_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rf_rom_addr", bus.rom_addr, 32'h4);
    checkOutput("rf_stalled", {31'b0, bus.stalled}, 32'h0);
    checkOutput("rf_instr", bus.instr, 32'h0);
    tick(1);
    checkOutput("rf1_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick(1);
    checkOutput("rf2_instr", bus.instr, 32'h2222_2222);
    checkOutput("rf2_pc", bus.instr_pc, 32'h4);
    checkOutput("rf2_rom_addr", bus.rom_addr, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
